// File: rtl/hub75_framebuffer.sv
// Double-buffered RGB frame store feeding a HUB75 scanner.
// A raster pixel stream fills the back bank; the scanner reads the front bank
// with 1-cycle latency. Banks swap only at a scanner frame boundary once a
// complete back frame exists, so the panel never shows a torn frame.
module hub75_framebuffer #(
  parameter  int HPIXEL_P   = 64,
  parameter  int VPIXEL_P   = 64,
  parameter  int BPP_P      = 8,
  localparam int FRAME_SIZE = HPIXEL_P * VPIXEL_P,
  localparam int ADDR_W     = $clog2(FRAME_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic                    i_wr_sof,
  input  logic [2:0][BPP_P-1:0]   i_wr_data,
  input  logic [ADDR_W-1:0]       i_rd_addr,
  output logic [2:0][BPP_P-1:0]   o_rd_data,
  input  logic                    i_frame_done,
  output logic                    o_front_sel,
  output logic                    o_frame_valid,
  output logic                    o_frame_swapped,
  output logic                    o_sof_err,
  output logic                    o_dropped
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    FILL,
    FULL
  } state_t;

  // Physical address is {bank, addr}, so the array spans two address-width banks.
  localparam int MEM_DEPTH = 2 ** (ADDR_W + 1);

  logic [3*BPP_P-1:0] mem [MEM_DEPTH];

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic                    front_sel_q, front_sel_d;
  logic                    frame_valid_q, frame_valid_d;
  logic                    swapped_q, swapped_d;
  logic                    sof_err_q, sof_err_d;
  logic                    dropped_q, dropped_d;
  logic [2:0][BPP_P-1:0]   rd_data_q, rd_data_d;

  logic                    wr_ready;
  logic                    wr_accept;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_idx;
  logic                    rd_in_range;

  assign wr_ready  = (state_q != FULL);
  assign wr_accept = i_wr_valid && wr_ready;

  // Write FSM: track fill progress, detect restarts/drops, swap banks in FULL.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    front_sel_d   = front_sel_q;
    frame_valid_d = frame_valid_q;
    swapped_d     = 1'b0;
    sof_err_d     = 1'b0;
    dropped_d     = 1'b0;
    wr_en         = 1'b0;
    wr_idx        = wr_addr_q;
    case (state_q)
      WAIT_SOF: begin
        if (wr_accept) begin
          if (i_wr_sof) begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            wr_addr_d = ADDR_W'(1);
            state_d   = FILL;
          end else begin
            dropped_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (wr_accept) begin
          wr_en = 1'b1;
          if (i_wr_sof) begin
            wr_idx    = '0;
            wr_addr_d = ADDR_W'(1);
            sof_err_d = 1'b1;
          end else if (wr_addr_q == ADDR_W'(FRAME_SIZE - 1)) begin
            wr_addr_d = '0;
            state_d   = FULL;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      FULL: begin
        if (i_frame_done) begin
          front_sel_d   = ~front_sel_q;
          frame_valid_d = 1'b1;
          swapped_d     = 1'b1;
          state_d       = WAIT_SOF;
        end
      end
      default: state_d = WAIT_SOF;
    endcase
  end

  assign rd_in_range = ({1'b0, i_rd_addr} < (ADDR_W + 1)'(FRAME_SIZE));

  // Front-bank read; black until a frame has been swapped in or when out of range.
  always_comb begin
    rd_data_d = '0;
    if (frame_valid_q && rd_in_range) begin
      rd_data_d = mem[{front_sel_q, i_rd_addr}];
    end
  end

  // Pixel storage write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{~front_sel_q, wr_idx}] <= i_wr_data;
    end
  end

  // State, bank selection, pulse and read-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= WAIT_SOF;
      wr_addr_q     <= '0;
      front_sel_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      swapped_q     <= 1'b0;
      sof_err_q     <= 1'b0;
      dropped_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      front_sel_q   <= front_sel_d;
      frame_valid_q <= frame_valid_d;
      swapped_q     <= swapped_d;
      sof_err_q     <= sof_err_d;
      dropped_q     <= dropped_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign o_wr_ready      = wr_ready;
  assign o_rd_data       = rd_data_q;
  assign o_front_sel     = front_sel_q;
  assign o_frame_valid   = frame_valid_q;
  assign o_frame_swapped = swapped_q;
  assign o_sof_err       = sof_err_q;
  assign o_dropped       = dropped_q;

endmodule

// File: tb/tb_hub75_framebuffer.sv
// Scoreboard bench for hub75_framebuffer: stimulus pushes expected read data
// and expected pulse events; a negedge monitor pops and compares them.
module tb_hub75_framebuffer;

  localparam int H  = 64;
  localparam int V  = 64;
  localparam int BW = 8;
  localparam int FS = H * V;
  localparam int AW = 12;

  localparam logic [2:0] EV_DROP = 3'b001;
  localparam logic [2:0] EV_ERR  = 3'b010;
  localparam logic [2:0] EV_SWAP = 3'b100;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_wr_valid;
  logic              o_wr_ready;
  logic              i_wr_sof;
  logic [2:0][BW-1:0] i_wr_data;
  logic [AW-1:0]     i_rd_addr;
  logic [2:0][BW-1:0] o_rd_data;
  logic              i_frame_done;
  logic              o_front_sel;
  logic              o_frame_valid;
  logic              o_frame_swapped;
  logic              o_sof_err;
  logic              o_dropped;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  logic [23:0] rd_exp_q[$];
  logic [2:0]  ev_exp_q[$];
  logic        rd_req = 1'b0;
  logic        rd_cap = 1'b0;
  logic [23:0] mon_rd;
  logic [2:0]  mon_ev;
  logic [2:0]  pulses;

  logic model_sel   = 1'b0;
  logic model_valid = 1'b0;
  int   front_tag   = 0;
  int   back_tag    = 0;

  hub75_framebuffer #(.HPIXEL_P(H), .VPIXEL_P(V), .BPP_P(BW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_wr_valid      (i_wr_valid),
    .o_wr_ready      (o_wr_ready),
    .i_wr_sof        (i_wr_sof),
    .i_wr_data       (i_wr_data),
    .i_rd_addr       (i_rd_addr),
    .o_rd_data       (o_rd_data),
    .i_frame_done    (i_frame_done),
    .o_front_sel     (o_front_sel),
    .o_frame_valid   (o_frame_valid),
    .o_frame_swapped (o_frame_swapped),
    .o_sof_err       (o_sof_err),
    .o_dropped       (o_dropped)
  );

  always #5 clk = ~clk;

  // Pixel pattern: R=addr[7:0], G={tag,addr[11:8]}, B=addr[7:0]^tag.
  function automatic logic [23:0] pix(input int a, input int tag);
    logic [7:0] r, g, b;
    r = 8'(a & 255);
    g = 8'(((tag & 15) << 4) | ((a >> 8) & 15));
    b = 8'((a & 255) ^ tag);
    return {b, g, r};
  endfunction

  function automatic logic [23:0] exp_rd(input int a);
    return model_valid ? pix(a, front_tag) : 24'h0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Read request is sampled by the DUT on the edge where rd_cap loads.
  always @(posedge clk) rd_cap <= rd_req;

  // Monitor: compare read data and any pulse output against the scoreboard.
  always @(negedge clk) begin
    if (rd_cap) begin
      if (rd_exp_q.size() == 0) begin
        checkOutput("rd_unexpected", 32'(o_rd_data), 32'hFFFF_FFFF);
      end else begin
        mon_rd = rd_exp_q.pop_front();
        checkOutput("rd_data", 32'(o_rd_data), 32'(mon_rd));
      end
    end
    pulses = {o_frame_swapped, o_sof_err, o_dropped};
    if (pulses != 3'b000) begin
      if (ev_exp_q.size() == 0) begin
        checkOutput("pulse_unexpected", 32'(pulses), 32'h0);
      end else begin
        mon_ev = ev_exp_q.pop_front();
        checkOutput("pulse_event", 32'(pulses), 32'(mon_ev));
      end
    end
  end

  task automatic applyStimulus(input logic valid, input logic sof, input logic [23:0] data,
                               input logic done);
    logic rdy;
    int   tries;
    i_wr_valid   = valid;
    i_wr_sof     = sof;
    i_wr_data    = data;
    i_frame_done = done;
    rdy = o_wr_ready;
    @(posedge clk);
    #1;
    i_frame_done = 1'b0;
    tries = 0;
    while (valid && !rdy && tries < 50) begin
      stalls++;
      rdy = o_wr_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (valid && !rdy) checkOutput("accept_timeout", 32'(rdy), 32'h1);
    i_wr_valid = 1'b0;
    i_wr_sof   = 1'b0;
  endtask

  task automatic doRead(input int a, input logic [23:0] exp);
    i_rd_addr = AW'(a);
    rd_req    = 1'b1;
    rd_exp_q.push_back(exp);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic sendFrame(input int tag, input int n, input logic restart, input logic done_last);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && restart) ev_exp_q.push_back(EV_ERR);
      if (i == n / 2) begin
        i_rd_addr = AW'(7);
        rd_req    = 1'b1;
        rd_exp_q.push_back(exp_rd(7));
      end
      if (i == n - 1 && n == FS) checkOutput("ready_before_last", 32'(o_wr_ready), 32'h1);
      applyStimulus(1'b1, i == 0, pix(i, tag), done_last && (i == n - 1));
      rd_req = 1'b0;
    end
    checkOutput("fill_stalls", 32'(stalls), 32'h0);
    if (n == FS) checkOutput("full_after_last", 32'(o_wr_ready), 32'h0);
  endtask

  task automatic doSwap();
    i_rd_addr = AW'(12'h040);
    rd_req    = 1'b1;
    rd_exp_q.push_back(exp_rd(12'h040));
    ev_exp_q.push_back(EV_SWAP);
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    rd_req      = 1'b0;
    model_sel   = ~model_sel;
    model_valid = 1'b1;
    front_tag   = back_tag;
    checkOutput("swap_front_sel", 32'(o_front_sel), 32'(model_sel));
    checkOutput("swap_frame_valid", 32'(o_frame_valid), 32'h1);
    checkOutput("swap_ready", 32'(o_wr_ready), 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    i_wr_valid   = 1'b0;
    i_wr_sof     = 1'b0;
    i_wr_data    = '0;
    i_rd_addr    = '0;
    i_frame_done = 1'b0;
    idle(3);
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_ready", 32'(o_wr_ready), 32'h1);
    checkOutput("rst_frame_valid", 32'(o_frame_valid), 32'h0);
    checkOutput("rst_front_sel", 32'(o_front_sel), 32'h0);
    checkOutput("rst_rd_data", 32'(o_rd_data), 32'h0);
    doRead(5, 24'h0);

    // frame_done while waiting for SOF is ignored
    applyStimulus(1'b0, 1'b0, 24'h0, 1'b1);
    idle(2);
    checkOutput("early_done_sel", 32'(o_front_sel), 32'h0);

    // Three beats without SOF are dropped
    for (int k = 0; k < 3; k++) begin
      ev_exp_q.push_back(EV_DROP);
      applyStimulus(1'b1, 1'b0, 24'hABCDEF, 1'b0);
    end

    // First full frame, held in FULL until the scanner finishes
    sendFrame(0, FS, 1'b0, 1'b0);
    back_tag = 0;
    idle(3);
    checkOutput("hold_full_ready", 32'(o_wr_ready), 32'h0);
    checkOutput("hold_full_sel", 32'(o_front_sel), 32'h0);
    doRead(12'h123, 24'h0);
    doSwap();
    doRead(12'h123, 24'h230123);
    doRead(0, exp_rd(0));
    doRead(FS - 1, exp_rd(FS - 1));

    // Restart at pixel 100: sof_err, then a full frame from that SOF
    sendFrame(2, 100, 1'b0, 1'b0);
    sendFrame(3, FS, 1'b1, 1'b0);
    back_tag = 3;
    doSwap();
    doRead(50, exp_rd(50));
    doRead(12'h123, exp_rd(12'h123));
    doRead(4000, exp_rd(4000));

    // frame_done on the last pixel does not swap
    sendFrame(4, FS, 1'b0, 1'b1);
    back_tag = 4;
    idle(2);
    checkOutput("coincide_sel", 32'(o_front_sel), 32'(model_sel));
    checkOutput("coincide_ready", 32'(o_wr_ready), 32'h0);
    doSwap();
    doRead(12'h123, exp_rd(12'h123));

    // Reset mid-fill with a valid front frame
    sendFrame(5, 500, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(2);
    rst_n       = 1'b1;
    model_sel   = 1'b0;
    model_valid = 1'b0;
    checkOutput("midrst_frame_valid", 32'(o_frame_valid), 32'h0);
    checkOutput("midrst_front_sel", 32'(o_front_sel), 32'h0);
    checkOutput("midrst_ready", 32'(o_wr_ready), 32'h1);
    doRead(12'h123, 24'h0);
    sendFrame(6, FS, 1'b0, 1'b0);
    back_tag = 6;
    doSwap();
    doRead(12'h123, exp_rd(12'h123));
    doRead(0, exp_rd(0));

    idle(3);
    checkOutput("rd_queue_empty", 32'(rd_exp_q.size()), 32'h0);
    checkOutput("event_queue_empty", 32'(ev_exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
